// File: rtl/touch_led_ctrl.sv
// touch_led_ctrl
// Touch-key LED controller. The raw touch level is synchronized and
// debounced. Each debounced press is classified as short or long, and the
// result steps a four-mode LED state machine: OFF, ON, SLOW blink, FAST blink.
module touch_led_ctrl #(
   parameter int DEB_CNT    = 1_000_000,
   parameter int LONG_CNT   = 50_000_000,
   parameter int BLINK_SLOW = 25_000_000,
   parameter int BLINK_FAST = 5_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       touch_key,
   output logic       led,
   output logic [1:0] mode,
   output logic       press_short,
   output logic       press_long
);

   localparam int DEB_W   = $clog2(DEB_CNT + 1);
   localparam int LONG_W  = $clog2(LONG_CNT + 1);
   localparam int BLK_MAX = (BLINK_SLOW > BLINK_FAST) ? BLINK_SLOW : BLINK_FAST;
   localparam int BLK_W   = $clog2(BLK_MAX + 1);

   localparam logic [DEB_W-1:0]  DEB_ZERO  = DEB_W'(0);
   localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
   localparam logic [LONG_W-1:0] LONG_ZERO = LONG_W'(0);
   localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
   localparam logic [BLK_W-1:0]  BLK_ZERO  = BLK_W'(0);
   localparam logic [BLK_W-1:0]  BLK_ONE   = BLK_W'(1);
   localparam logic [BLK_W-1:0]  SLOW_LAST = BLK_W'(BLINK_SLOW - 1);
   localparam logic [BLK_W-1:0]  FAST_LAST = BLK_W'(BLINK_FAST - 1);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_SLOW = 2'd2,
      ST_FAST = 2'd3
   } state_t;

   logic              sync1_r;
   logic              sync2_r;
   logic              key_db_r;
   logic              key_db_d_r;
   logic [DEB_W-1:0]  deb_cnt_r;
   logic [LONG_W-1:0] hold_cnt_r;
   logic [BLK_W-1:0]  blink_cnt_r;
   state_t            state_r;
   logic              deb_rise_s;

   // The debouncer accepts a new high level on this cycle, so the hold count restarts here.
   assign deb_rise_s = sync2_r && !key_db_r && (deb_cnt_r == DEB_LAST);

   assign mode = state_r;

   // Two-flop synchronizer for the asynchronous touch input.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= touch_key;
         sync2_r <= sync1_r;
      end
   end

   // Debouncer: accept a level change only after DEB_CNT consecutive differing cycles.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_db_r  <= 1'b0;
         deb_cnt_r <= DEB_ZERO;
      end else if (sync2_r != key_db_r) begin
         if (deb_cnt_r == DEB_LAST) begin
            key_db_r  <= sync2_r;
            deb_cnt_r <= DEB_ZERO;
         end else begin
            deb_cnt_r <= deb_cnt_r + DEB_ONE;
         end
      end else begin
         deb_cnt_r <= DEB_ZERO;
      end
   end

   // Hold-time measurement and one-cycle short/long press pulses.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_db_d_r  <= 1'b0;
         hold_cnt_r  <= LONG_ZERO;
         press_short <= 1'b0;
         press_long  <= 1'b0;
      end else begin
         key_db_d_r  <= key_db_r;
         press_short <= key_db_d_r && !key_db_r && (hold_cnt_r < LONG_MAX);
         press_long  <= 1'b0;
         if (deb_rise_s) begin
            hold_cnt_r <= LONG_ZERO;
         end else if (key_db_r && (hold_cnt_r != LONG_MAX)) begin
            hold_cnt_r <= hold_cnt_r + LONG_ONE;
            press_long <= (hold_cnt_r == LONG_LAST);
         end else begin
            hold_cnt_r <= hold_cnt_r;
         end
      end
   end

   // Mode state machine with registered LED drive and blink timing.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r     <= ST_OFF;
         led         <= 1'b0;
         blink_cnt_r <= BLK_ZERO;
      end else begin
         case (state_r)
            ST_OFF: begin
               blink_cnt_r <= BLK_ZERO;
               if (press_short || press_long) begin
                  state_r <= ST_ON;
                  led     <= 1'b1;
               end else begin
                  led <= 1'b0;
               end
            end
            ST_ON: begin
               blink_cnt_r <= BLK_ZERO;
               if (press_short) begin
                  state_r <= ST_SLOW;
                  led     <= 1'b1;
               end else if (press_long) begin
                  state_r <= ST_OFF;
                  led     <= 1'b0;
               end else begin
                  led <= 1'b1;
               end
            end
            ST_SLOW: begin
               if (press_short) begin
                  state_r     <= ST_FAST;
                  led         <= 1'b1;
                  blink_cnt_r <= BLK_ZERO;
               end else if (press_long) begin
                  state_r     <= ST_OFF;
                  led         <= 1'b0;
                  blink_cnt_r <= BLK_ZERO;
               end else if (blink_cnt_r == SLOW_LAST) begin
                  led         <= ~led;
                  blink_cnt_r <= BLK_ZERO;
               end else begin
                  blink_cnt_r <= blink_cnt_r + BLK_ONE;
               end
            end
            ST_FAST: begin
               if (press_short || press_long) begin
                  state_r     <= ST_OFF;
                  led         <= 1'b0;
                  blink_cnt_r <= BLK_ZERO;
               end else if (blink_cnt_r == FAST_LAST) begin
                  led         <= ~led;
                  blink_cnt_r <= BLK_ZERO;
               end else begin
                  blink_cnt_r <= blink_cnt_r + BLK_ONE;
               end
            end
            default: begin
               state_r     <= ST_OFF;
               led         <= 1'b0;
               blink_cnt_r <= BLK_ZERO;
            end
         endcase
      end
   end

endmodule
